// File: rtl/sample_interp_upsampler.sv
// Upsampling feeder for the delta-sigma PWM modulator: 2-entry sample FIFO plus per-request interpolator.
// Define SAMPLE_INTERP_LINEAR_EN for linear interpolation; the default build is a zero-order hold.
module sample_interp_upsampler #(
  parameter int unsigned IN_BITS        = 16,
  parameter int unsigned MAX_LOG2_RATIO = 6,
  parameter int unsigned RATIO_BITS     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [IN_BITS-1:0]    in_data,
  output logic                  in_ready,
  input  logic [RATIO_BITS-1:0] log2_ratio,
  input  logic                  sample_req,
  output logic [IN_BITS-1:0]    u_out,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int unsigned KW = MAX_LOG2_RATIO;

  // FIFO storage and bookkeeping
  logic [IN_BITS-1:0] mem_q [2];
  logic [IN_BITS-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               ready_q, ready_d;

  // Interpolator state
  logic [IN_BITS-1:0]    curr_q, curr_d;
  logic [IN_BITS-1:0]    u_q, u_d;
  logic [KW-1:0]         k_q, k_d;
  logic [RATIO_BITS-1:0] l_q, l_d;
  logic                  ur_q, ur_d;

  logic                  push, load, pop, has_head;
  logic [IN_BITS-1:0]    head;
  logic [RATIO_BITS-1:0] l_new;
  logic [KW-1:0]         k_ones, k_mask;

  assign push     = in_valid && ready_q;
  assign load     = sample_req && (k_q == '0);
  assign has_head = (cnt_q != 2'd0);
  assign pop      = load && has_head;
  assign head     = mem_q[rd_ptr_q];
  assign l_new    = (log2_ratio > RATIO_BITS'(MAX_LOG2_RATIO)) ? RATIO_BITS'(MAX_LOG2_RATIO)
                                                              : log2_ratio;
  // k wraps modulo the ratio latched for the current segment
  assign k_ones   = '1;
  assign k_mask   = ~(k_ones << l_q);

`ifdef SAMPLE_INTERP_LINEAR_EN
  localparam int unsigned DW = IN_BITS + 1;
  localparam int unsigned AW = IN_BITS + MAX_LOG2_RATIO + 1;

  logic signed [DW-1:0] delta_q, delta_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] head_diff, load_delta;
  logic        [AW-1:0] base_sh, load_ext, delta_ext;

  assign head_diff  = $signed({1'b0, head}) - $signed({1'b0, curr_q});
  assign load_delta = has_head ? head_diff : '0;
  assign load_ext   = {{(AW-DW){load_delta[DW-1]}}, load_delta};
  assign delta_ext  = {{(AW-DW){delta_q[DW-1]}}, delta_q};
  assign base_sh    = AW'(curr_q) << l_new;
`endif

  // Next-state logic
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    curr_d   = curr_q;
    u_d      = u_q;
    k_d      = k_q;
    l_d      = l_q;
    ur_d     = ur_q;
`ifdef SAMPLE_INTERP_LINEAR_EN
    delta_d  = delta_q;
    acc_d    = acc_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != 2'd2);

    // A new underrun in the same cycle as a clear leaves the flag set
    if (underrun_clr) begin
      ur_d = 1'b0;
    end

    if (load) begin
      l_d = l_new;
      k_d = (l_new != '0) ? KW'(1) : '0;
      if (has_head) begin
        curr_d = head;
      end else begin
        ur_d = 1'b1;
      end
`ifdef SAMPLE_INTERP_LINEAR_EN
      u_d     = curr_q;
      delta_d = load_delta;
      acc_d   = base_sh + load_ext;
`else
      u_d     = has_head ? head : curr_q;
`endif
    end else if (sample_req) begin
      k_d = (k_q + KW'(1)) & k_mask;
`ifdef SAMPLE_INTERP_LINEAR_EN
      // acc holds base*R + delta*k and stays non-negative, so the shift is a floor divide
      u_d   = IN_BITS'(acc_q >>> l_q);
      acc_d = acc_q + delta_ext;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b1;
      curr_q   <= '0;
      u_q      <= '0;
      k_q      <= '0;
      l_q      <= '0;
      ur_q     <= 1'b0;
`ifdef SAMPLE_INTERP_LINEAR_EN
      delta_q  <= '0;
      acc_q    <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      curr_q   <= curr_d;
      u_q      <= u_d;
      k_q      <= k_d;
      l_q      <= l_d;
      ur_q     <= ur_d;
`ifdef SAMPLE_INTERP_LINEAR_EN
      delta_q  <= delta_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign in_ready = ready_q;
  assign u_out    = u_q;
  assign underrun = ur_q;

endmodule

// File: tb/tb_sample_interp_upsampler.sv
// Bench for sample_interp_upsampler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a segment-level arithmetic model.
module tb_sample_interp_upsampler;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [2:0]  log2_ratio;
  logic        sample_req;
  logic [15:0] u_out;
  logic        underrun;
  logic        underrun_clr;

  sample_interp_upsampler #(.IN_BITS(16), .MAX_LOG2_RATIO(6), .RATIO_BITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .log2_ratio   (log2_ratio),
    .sample_req   (sample_req),
    .u_out        (u_out),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO queue, segment base/delta, position k within the segment
  int q[$];
  int m_curr = 0, m_k = 0, m_L = 0, m_base = 0, m_delta = 0, m_u = 0;
  bit m_ur = 1'b0;
  bit m_rdy = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
  endtask

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  task automatic model_step();
    bit had, rdy;
    int hd;
    if (reset) begin
      q.delete();
      m_curr = 0; m_k = 0; m_L = 0; m_base = 0; m_delta = 0; m_u = 0; m_ur = 1'b0;
      m_rdy = 1'b1;
      return;
    end
    rdy = (q.size() < 2);
    had = (q.size() != 0);
    hd  = had ? q[0] : 0;
    if (underrun_clr) m_ur = 1'b0;
    if (sample_req) begin
      if (m_k == 0) begin
        m_L    = (int'(log2_ratio) > 6) ? 6 : int'(log2_ratio);
        m_base = m_curr;
        if (had) begin
          void'(q.pop_front());
          m_delta = hd - m_base;
          m_curr  = hd;
        end else begin
          m_delta = 0;
          m_ur    = 1'b1;
        end
`ifdef SAMPLE_INTERP_LINEAR_EN
        m_u = m_base;
`else
        m_u = m_curr;
`endif
        m_k = (m_L > 0) ? 1 : 0;
      end else begin
`ifdef SAMPLE_INTERP_LINEAR_EN
        m_u = m_base + floor_div(m_delta * m_k, 1 << m_L);
`endif
        m_k = (m_k + 1) % (1 << m_L);
      end
    end
    if (in_valid && rdy) q.push_back(int'(in_data));
    m_rdy = (q.size() < 2);
  endtask

  // Every clock edge passes through here so the model stays in lockstep with the DUT
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u_out", 32'(u_out), 32'(m_u));
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("underrun", 32'(underrun), 32'(m_ur));
    end
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; sample_req = 1'b0; underrun_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input int v);
    bit rdy, done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(v);
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic req();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  initial begin
    int e1[8], e2[8], e4[6];
    reset = 1'b1; in_valid = 1'b0; in_data = '0; log2_ratio = 3'd2;
    sample_req = 1'b0; underrun_clr = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_u_out", 32'(u_out), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_underrun", 32'(underrun), 32'(0));
`ifdef SAMPLE_INTERP_LINEAR_EN
    e1 = '{0, 250, 500, 750, 1000, 1250, 1500, 1750};
    e2 = '{0, 500, 1000, 1500, 2000, 1750, 1500, 1250};
    e4 = '{0, 100, 200, 300, 400, 800};
`else
    e1 = '{1000, 1000, 1000, 1000, 2000, 2000, 2000, 2000};
    e2 = '{2000, 2000, 2000, 2000, 1000, 1000, 1000, 1000};
    e4 = '{400, 400, 400, 400, 800, 800};
`endif
    reset = 1'b0;

    // Ascending ramp
    push(1000); push(2000);
    for (int i = 0; i < 8; i++) begin req(); chk("ramp_up", 32'(u_out), 32'(e1[i])); end

    // Descending ramp, then an underrun segment holding curr
    do_reset(); log2_ratio = 3'd2;
    push(2000); push(1000);
    for (int i = 0; i < 8; i++) begin req(); chk("ramp_down", 32'(u_out), 32'(e2[i])); end
    for (int i = 0; i < 4; i++) begin
      req();
      chk("underrun_hold", 32'(u_out), 32'(1000));
      chk("underrun_set", 32'(underrun), 32'(1));
    end
    underrun_clr = 1'b1; req(); underrun_clr = 1'b0;
    chk("clr_vs_set", 32'(underrun), 32'(1));
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    chk("clr_alone", 32'(underrun), 32'(0));

    // Backpressure: third push held until the first load frees a slot
    do_reset(); log2_ratio = 3'd2;
    in_valid = 1'b1; in_data = 16'd11; tick();
    in_data = 16'd22; tick();
    chk("bp_full", 32'(in_ready), 32'(0));
    in_data = 16'd33;
    for (int i = 0; i < 3; i++) begin tick(); chk("bp_held", 32'(in_ready), 32'(0)); end
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    chk("bp_after_pop", 32'(in_ready), 32'(1));
`ifdef SAMPLE_INTERP_LINEAR_EN
    chk("bp_load_u", 32'(u_out), 32'(0));
`else
    chk("bp_load_u", 32'(u_out), 32'(11));
`endif
    tick(); in_valid = 1'b0;
    chk("bp_third_in", 32'(in_ready), 32'(0));
    for (int i = 0; i < 7; i++) req();
    req();
`ifdef SAMPLE_INTERP_LINEAR_EN
    chk("bp_third_seg", 32'(u_out), 32'(22));
`else
    chk("bp_third_seg", 32'(u_out), 32'(33));
`endif

    // Ratio change mid-segment takes effect at the next load
    do_reset(); log2_ratio = 3'd2;
    push(400); push(800);
    for (int i = 0; i < 6; i++) begin
      req();
      if (i == 1) log2_ratio = 3'd0;
      chk("ratio_change", 32'(u_out), 32'(e4[i]));
      if (i == 4) chk("ratio_ur0", 32'(underrun), 32'(0));
    end
    chk("ratio_ur1", 32'(underrun), 32'(1));

    // log2_ratio=7 clamps to 64 requests per segment
    do_reset(); log2_ratio = 3'd7;
    push(6400);
    for (int i = 1; i <= 65; i++) begin
      req();
`ifdef SAMPLE_INTERP_LINEAR_EN
      if (i == 2)  chk("clamp_j1", 32'(u_out), 32'(100));
      if (i == 64) chk("clamp_j63", 32'(u_out), 32'(6300));
`else
      if (i == 2)  chk("clamp_j1", 32'(u_out), 32'(6400));
      if (i == 64) chk("clamp_j63", 32'(u_out), 32'(6400));
`endif
      if (i == 64) chk("clamp_ur0", 32'(underrun), 32'(0));
    end
    chk("clamp_ur1", 32'(underrun), 32'(1));
    chk("clamp_reload", 32'(u_out), 32'(6400));

    // Reset mid-segment with one entry buffered
    do_reset(); log2_ratio = 3'd2;
    push(100); push(200); req(); req();
    reset = 1'b1; sample_req = 1'b1; tick(); reset = 1'b0; sample_req = 1'b0;
    chk("mid_rst_u", 32'(u_out), 32'(0));
    chk("mid_rst_rdy", 32'(in_ready), 32'(1));
    chk("mid_rst_ur", 32'(underrun), 32'(0));
    push(500); req();
`ifdef SAMPLE_INTERP_LINEAR_EN
    chk("post_rst_load", 32'(u_out), 32'(0));
    req(); chk("post_rst_j1", 32'(u_out), 32'(125));
`else
    chk("post_rst_load", 32'(u_out), 32'(500));
    req(); chk("post_rst_j1", 32'(u_out), 32'(500));
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      in_valid     = ($urandom_range(0, 1) == 1);
      in_data      = 16'($urandom);
      sample_req   = ($urandom_range(0, 2) == 0);
      underrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) log2_ratio = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; sample_req = 1'b0; underrun_clr = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sample_interp_upsampler.md
Name: sample_interp_upsampler

Overview:
- Upstream feeder for the delta-sigma PWM modulator.
- Accepts input samples at a low rate over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents a new interpolated value on u_out for every sample_req pulse (driven by the modulator's pulse_done).
- Linearly interpolates 2^log2_ratio output values per input sample, so the modulator sees a smooth ramp instead of a staircase.

Parameters:
- IN_BITS, 16, sample width; samples are unsigned, matching the modulator u input.
- MAX_LOG2_RATIO, 6, largest supported log2 of the upsampling ratio.
- RATIO_BITS, 3, width of log2_ratio.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_data  in  IN_BITS  input sample, unsigned.
- in_ready  out  1  FIFO can accept a sample; equals !full.
- log2_ratio  in  RATIO_BITS  upsampling ratio R = 1<<log2_ratio. Values above MAX_LOG2_RATIO are clamped to MAX_LOG2_RATIO.
- sample_req  in  1  single-cycle request for the next output value.
- u_out  out  IN_BITS  registered output value to the modulator.
- underrun  out  1  sticky flag: a segment started while the FIFO was empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-segment state):
  - u_out=0, underrun=0, FIFO empty, in_ready=1.
  - curr=0, acc=0, delta=0, phase k=0, latched ratio L=0.
- FIFO:
  - 2 entries; push when in_valid && in_ready; pop only at a segment load.
  - Push and pop in the same cycle are both performed. Occupancy is unchanged, and a push into an empty FIFO is not visible to a pop in that same cycle.
  - in_data is ignored while in_ready=0.
- Datapath:
  - curr: IN_BITS, the last sample loaded.
  - delta: signed IN_BITS+1.
  - acc: signed IN_BITS+MAX_LOG2_RATIO+1, never negative in normal operation.
  - k: MAX_LOG2_RATIO bits.
  - L: latched log2 ratio.
- On sample_req with k==0 (segment load):
  - Latch L from log2_ratio (clamped); L changes only here.
  - base = curr; u_out <= base.
  - FIFO non-empty: pop head; curr <= head; delta <= head - base; acc <= (base<<L_new) + (head - base).
  - FIFO empty: delta <= 0; acc <= base<<L_new; curr unchanged; underrun <= 1.
  - k <= 1 if L_new>0, else k stays 0.
- On sample_req with k!=0:
  - u_out <= acc >>> L (arithmetic; floor); acc <= acc + delta.
  - k <= (k+1) mod (1<<L).
- Resulting sequence per segment: u_out_j = base + floor(delta*j / R) for j = 0..R-1, continuous into the next segment's base.
- Latency:
  - u_out updates the cycle after sample_req and holds until the next sample_req.
  - A sample reaches u_out as the base of the segment after the one in which it was loaded, i.e. one segment of delay.
- No sample_req: all state is held; FIFO may still fill.
- R=1 (L=0): every request is a load and u_out tracks the loaded samples with one-request delay.
- underrun:
  - underrun_clr clears it.
  - If underrun_clr coincides with a new underrun event, set wins.
- sample_req while reset=1: ignored.

Optional Feature:
- Macro: SAMPLE_INTERP_LINEAR_EN.
- Defined: linear interpolation exactly as described above.
- Undefined: zero-order hold.
  - delta and acc are not implemented.
  - At a load, u_out <= head (or curr on underrun), with no segment delay.
  - For k!=0, u_out is held.
  - FIFO, k, L and underrun behaviour are otherwise identical.

Test Plan:
- After reset, push 1000 then 2000 with L=2, then issue 8 sample_req: with the macro defined, u_out sequence is 0,250,500,750,1000,1250,1500,1750; with it undefined, u_out is 1000 ×4 then 2000 ×4.
- Descending ramp: push 2000 then 1000 with L=2; after the first segment, u_out reads 2000,1750,1500,1250 (verifies the signed delta and floor behaviour with no negative overshoot).
- Backpressure: push 3 samples back-to-back with no sample_req: in_ready drops after the 2nd push, the 3rd is held off, and the 3rd push completes in the cycle after the first load pops.
- Underrun: run one load with an empty FIFO: underrun=1, u_out holds curr for R requests. Assert underrun_clr together with a second underrun: flag remains 1. Assert underrun_clr alone: flag clears.
- Change log2_ratio from 2 to 0 at k=2: k continues 3 then 0 under the old ratio, and the new ratio takes effect from the next load. Set log2_ratio=7: behaves as 6 (64 requests per segment).
- Assert reset mid-segment (k=2) with FIFO holding one entry: next cycle u_out=0, in_ready=1, underrun=0, and the next sample_req performs a load.
